sync_fifo_ext: RTL and testbench
================================

SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of storage entries (any integer >= 2, not restricted to powers of two).
REQ-003 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-1: almost_full asserts when level >= AF_THRESH; legal range 1..DEPTH.
REQ-005 SHALL have parameter AE_THRESH, default 1: almost_empty asserts when level <= AE_THRESH; legal range 0..DEPTH-1.
REQ-006 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port write_en  input  1  write request.
REQ-009 SHALL have port write_data  input  WIDTH  write word.
REQ-010 SHALL have port read_en  input  1  read request (acknowledge of head word in FWFT mode).
REQ-011 SHALL have port read_data  output  WIDTH  read word.
REQ-012 SHALL have port read_valid  output  1  read_data holds a valid word.
REQ-013 SHALL have port full / empty  output  1 each  level == DEPTH / level == 0.
REQ-014 SHALL have port almost_full / almost_empty  output  1 each  threshold flags.
REQ-015 SHALL have port level  output  $clog2(DEPTH+1)  current number of stored words.
REQ-016 SHALL have port overflow / underflow  output  1 each  one-cycle error pulses.

Function
REQ-017 Write accepted = write_en && !full; accepted word stored at write pointer, pointer advances.
REQ-018 Read accepted = read_en && !empty; read pointer advances.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0 by explicit compare, correct for non-power-of-two DEPTH.
REQ-020 level: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither; never exceeds DEPTH or drops below 0.
REQ-021 full, empty, almost_full, almost_empty SHALL be combinational decodes of the registered level.
REQ-022 Simultaneous write_en and read_en when full: read accepted, write rejected (overflow pulse); when empty: write accepted, read rejected (underflow pulse).
REQ-023 Rejected write SHALL not alter memory, pointer or level; overflow = 1 for exactly the cycle after the rejected request.
REQ-024 Rejected read SHALL not alter pointer, level or read_data; underflow = 1 for exactly the cycle after the rejected request.
REQ-025 FWFT=0: accepted read registers the head word into read_data at that edge; read_valid = 1 for the following cycle only; read_data holds its value otherwise.
REQ-026 FWFT=1: read_data = head entry whenever !empty; read_valid = !empty; accepted read presents the next entry in the following cycle; zero-latency visibility of the first write one cycle after acceptance.
REQ-027 Order SHALL be strictly first-in first-out across any number of pointer wraps.

Reset
REQ-028 reset low SHALL asynchronously clear pointers and level to 0, read_data to 0, read_valid, overflow, underflow to 0; thus empty = 1, full = 0, almost_empty = 1, almost_full = 0 (given legal thresholds).
REQ-029 Memory contents SHALL not be reset; reset mid-operation discards all stored words and ignores write_en/read_en while low.
REQ-030 Operation SHALL resume on the first rising clk edge after reset deasserts.

Verification (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2 unless stated)
REQ-031 Write 0x01..0x08, then 9th write 0x09 -> full=1, level=8, overflow=1 one cycle; reads return 0x01..0x08, 0x09 never appears.
REQ-032 Level sweep 0..8..0 -> almost_empty=1 for level 0..2, almost_full=1 for level 6..8; level matches writes minus reads every cycle.
REQ-033 Read while empty -> underflow=1 one cycle, level stays 0, read_data unchanged; simultaneous write+read when empty -> level=1, underflow=1.
REQ-034 DEPTH=6: 20 interleaved writes/reads of an incrementing pattern -> output sequence identical, no loss across 3+ wraps.
REQ-035 FWFT=1: write 0xA5 -> next cycle read_valid=1, read_data=0xA5 without read_en; read_en -> empty=1, read_valid=0 next cycle.
REQ-036 Assert reset mid-burst with level=5 -> immediately level=0, empty=1, read_valid=0; next write 0x3C then read returns 0x3C.

Source files
------------

// File: rtl/sync_fifo_ext_if.sv
// Handshake and status bundle between a producer/consumer and sync_fifo_ext.
// The master drives the write/read requests; the FIFO (slave) drives data and status.
interface sync_fifo_ext_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             write_en;
    logic [WIDTH-1:0] write_data;
    logic             read_en;
    logic [WIDTH-1:0] read_data;
    logic             read_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;

    modport master (
        output write_en, write_data, read_en,
        input  read_data, read_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  write_en, write_data, read_en,
        output read_data, read_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with arbitrary depth, threshold flags, error pulses and
// selectable registered-read or first-word-fall-through output.
module sync_fifo_ext #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1
) (
    input  logic           clk,
    input  logic           reset,
    sync_fifo_ext_if.slave fifo
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
    localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             full, empty;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] head;

    // Status flags decode the registered level only, so they never glitch on requests.
    assign full   = (level_q == LVL_FULL);
    assign empty  = (level_q == '0);
    assign wr_acc = fifo.write_en && !full;
    assign rd_acc = fifo.read_en && !empty;
    assign head   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rdata_d  = rdata_q;

        // Explicit wrap compare keeps non-power-of-two depths correct.
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        end

        if (wr_acc && !rd_acc) begin
            level_d = level_q + LW'(1);
        end else if (rd_acc && !wr_acc) begin
            level_d = level_q - LW'(1);
        end

        if (rd_acc && (FWFT == 0)) begin
            rdata_d = head;
        end

        rvalid_d = rd_acc;
        ovf_d    = fifo.write_en && full;
        unf_d    = fifo.read_en && empty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately not cleared; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            mem_q[wr_ptr_q] <= fifo.write_data;
        end
    end

    assign fifo.full         = full;
    assign fifo.empty        = empty;
    assign fifo.almost_full  = (level_q >= LVL_AF);
    assign fifo.almost_empty = (level_q <= LVL_AE);
    assign fifo.level        = level_q;
    assign fifo.overflow     = ovf_q;
    assign fifo.underflow    = unf_q;
    assign fifo.read_data    = (FWFT != 0) ? head : rdata_q;
    assign fifo.read_valid   = (FWFT != 0) ? !empty : rvalid_q;
endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: three instances (depth 8 registered, depth 6 registered,
// depth 8 FWFT) checked against queue-based reference models.
module tb_sync_fifo_ext;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_ext_if #(.WIDTH(8), .DEPTH(8)) a_if ();
    sync_fifo_ext_if #(.WIDTH(8), .DEPTH(6)) b_if ();
    sync_fifo_ext_if #(.WIDTH(8), .DEPTH(8)) f_if ();

    sync_fifo_ext #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) dut_a (
        .clk(clk), .reset(reset), .fifo(a_if.slave));
    sync_fifo_ext #(.WIDTH(8), .DEPTH(6), .FWFT(0)) dut_b (
        .clk(clk), .reset(reset), .fifo(b_if.slave));
    sync_fifo_ext #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) dut_f (
        .clk(clk), .reset(reset), .fifo(f_if.slave));

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qf[$];
    logic [7:0] exp_rd_a, exp_rd_b;
    logic       exp_rv_a, exp_rv_b;
    logic       exp_ov_a, exp_ov_b, exp_ov_f;
    logic       exp_un_a, exp_un_b, exp_un_f;

    task automatic model_clear();
        qa.delete(); qb.delete(); qf.delete();
        exp_rd_a = 8'h00; exp_rd_b = 8'h00;
        exp_rv_a = 1'b0;  exp_rv_b = 1'b0;
        exp_ov_a = 1'b0;  exp_ov_b = 1'b0; exp_ov_f = 1'b0;
        exp_un_a = 1'b0;  exp_un_b = 1'b0; exp_un_f = 1'b0;
    endtask

    // Apply the FIFO rules to the requests presented at the coming edge.
    task automatic model_edge();
        if (!reset) begin
            model_clear();
            return;
        end
        exp_ov_a = a_if.write_en && (qa.size() == 8);
        exp_un_a = a_if.read_en && (qa.size() == 0);
        exp_rv_a = a_if.read_en && (qa.size() != 0);
        if (exp_rv_a) exp_rd_a = qa.pop_front();
        if (a_if.write_en && !exp_ov_a) qa.push_back(a_if.write_data);

        exp_ov_b = b_if.write_en && (qb.size() == 6);
        exp_un_b = b_if.read_en && (qb.size() == 0);
        exp_rv_b = b_if.read_en && (qb.size() != 0);
        if (exp_rv_b) exp_rd_b = qb.pop_front();
        if (b_if.write_en && !exp_ov_b) qb.push_back(b_if.write_data);

        exp_ov_f = f_if.write_en && (qf.size() == 8);
        exp_un_f = f_if.read_en && (qf.size() == 0);
        if (f_if.read_en && qf.size() != 0) void'(qf.pop_front());
        if (f_if.write_en && !exp_ov_f) qf.push_back(f_if.write_data);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_if.write_en = 1'b0; a_if.read_en = 1'b0; a_if.write_data = 8'h00;
        b_if.write_en = 1'b0; b_if.read_en = 1'b0; b_if.write_data = 8'h00;
        f_if.write_en = 1'b0; f_if.read_en = 1'b0; f_if.write_data = 8'h00;
    endtask

    function automatic logic [18:0] exp_vec_a();
        int n = qa.size();
        return {4'(n), n == 8, n == 0, n >= 6, n <= 2, exp_rv_a, exp_ov_a, exp_un_a, exp_rd_a};
    endfunction
    function automatic logic [18:0] obs_vec_a();
        return {a_if.level, a_if.full, a_if.empty, a_if.almost_full, a_if.almost_empty,
                a_if.read_valid, a_if.overflow, a_if.underflow, a_if.read_data};
    endfunction
    function automatic logic [17:0] exp_vec_b();
        int n = qb.size();
        return {3'(n), n == 6, n == 0, n >= 5, n <= 1, exp_rv_b, exp_ov_b, exp_un_b, exp_rd_b};
    endfunction
    function automatic logic [17:0] obs_vec_b();
        return {b_if.level, b_if.full, b_if.empty, b_if.almost_full, b_if.almost_empty,
                b_if.read_valid, b_if.overflow, b_if.underflow, b_if.read_data};
    endfunction
    function automatic logic [10:0] exp_vec_f();
        int n = qf.size();
        return {4'(n), n == 8, n == 0, n >= 6, n <= 2, n != 0, exp_ov_f, exp_un_f};
    endfunction
    function automatic logic [10:0] obs_vec_f();
        return {f_if.level, f_if.full, f_if.empty, f_if.almost_full, f_if.almost_empty,
                f_if.read_valid, f_if.overflow, f_if.underflow};
    endfunction

    task automatic test_reset();
        idle_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        tests++; if (a_if.level !== 4'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", a_if.level); end
        tests++; if (a_if.empty !== 1'b1 || a_if.full !== 1'b0) begin fails++; $display("FAIL reset_full_empty: got full=%b empty=%b want 0/1", a_if.full, a_if.empty); end
        tests++; if (a_if.almost_empty !== 1'b1 || a_if.almost_full !== 1'b0) begin fails++; $display("FAIL reset_almost: got ae=%b af=%b want 1/0", a_if.almost_empty, a_if.almost_full); end
        tests++; if (a_if.read_data !== 8'h00 || a_if.read_valid !== 1'b0) begin fails++; $display("FAIL reset_read: got data=%h valid=%b want 00/0", a_if.read_data, a_if.read_valid); end
        tests++; if (a_if.overflow !== 1'b0 || a_if.underflow !== 1'b0) begin fails++; $display("FAIL reset_pulses: got ovf=%b unf=%b want 0/0", a_if.overflow, a_if.underflow); end
        tests++; if (f_if.read_valid !== 1'b0 || f_if.empty !== 1'b1) begin fails++; $display("FAIL reset_fwft: got valid=%b empty=%b want 0/1", f_if.read_valid, f_if.empty); end
        tests++; if (b_if.empty !== 1'b1 || b_if.level !== 3'd0) begin fails++; $display("FAIL reset_depth6: got empty=%b level=%0d want 1/0", b_if.empty, b_if.level); end
        cycle();
        reset = 1'b1;
        cycle();
        tests++; if (obs_vec_a() !== exp_vec_a()) begin fails++; $display("FAIL reset_idle_after: got %h want %h", obs_vec_a(), exp_vec_a()); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) begin
            a_if.write_en = 1'b1; a_if.write_data = 8'(i);
            cycle();
            tests++; if (a_if.level !== 4'(i)) begin fails++; $display("FAIL fill_level: got %0d want %0d", a_if.level, i); end
        end
        a_if.write_data = 8'h09;
        cycle();
        a_if.write_en = 1'b0;
        tests++; if (a_if.full !== 1'b1 || a_if.level !== 4'd8) begin fails++; $display("FAIL ovf_full: got full=%b level=%0d want 1/8", a_if.full, a_if.level); end
        tests++; if (a_if.overflow !== 1'b1) begin fails++; $display("FAIL ovf_pulse: got %b want 1", a_if.overflow); end
        cycle();
        tests++; if (a_if.overflow !== 1'b0 || a_if.level !== 4'd8) begin fails++; $display("FAIL ovf_clear: got ovf=%b level=%0d want 0/8", a_if.overflow, a_if.level); end
        for (int i = 1; i <= 8; i++) begin
            a_if.read_en = 1'b1;
            cycle();
            tests++; if (a_if.read_valid !== 1'b1 || a_if.read_data !== 8'(i)) begin fails++; $display("FAIL ovf_drain: got valid=%b data=%h want 1/%h", a_if.read_valid, a_if.read_data, 8'(i)); end
        end
        a_if.read_en = 1'b0;
        cycle();
        tests++; if (a_if.empty !== 1'b1 || a_if.read_valid !== 1'b0 || a_if.read_data !== 8'h08) begin fails++; $display("FAIL ovf_after: got empty=%b valid=%b data=%h want 1/0/08", a_if.empty, a_if.read_valid, a_if.read_data); end
    endtask

    task automatic test_level_sweep();
        for (int i = 0; i < 16; i++) begin
            a_if.write_en = (i < 8);
            a_if.read_en = (i >= 8);
            a_if.write_data = 8'($urandom);
            cycle();
            tests++; if (obs_vec_a() !== exp_vec_a()) begin fails++; $display("FAIL sweep_step%0d: got %h want %h", i, obs_vec_a(), exp_vec_a()); end
        end
        a_if.read_en = 1'b0;
    endtask

    task automatic test_underflow();
        a_if.read_en = 1'b1;
        cycle();
        a_if.read_en = 1'b0;
        tests++; if (a_if.underflow !== 1'b1 || a_if.level !== 4'd0) begin fails++; $display("FAIL unf_pulse: got unf=%b level=%0d want 1/0", a_if.underflow, a_if.level); end
        tests++; if (a_if.read_data !== exp_rd_a || a_if.read_valid !== 1'b0) begin fails++; $display("FAIL unf_data_held: got data=%h valid=%b want %h/0", a_if.read_data, a_if.read_valid, exp_rd_a); end
        cycle();
        tests++; if (a_if.underflow !== 1'b0) begin fails++; $display("FAIL unf_clear: got %b want 0", a_if.underflow); end
        a_if.write_en = 1'b1; a_if.read_en = 1'b1; a_if.write_data = 8'h5A;
        cycle();
        a_if.write_en = 1'b0; a_if.read_en = 1'b0;
        tests++; if (a_if.level !== 4'd1 || a_if.underflow !== 1'b1 || a_if.read_valid !== 1'b0) begin fails++; $display("FAIL unf_simul: got level=%0d unf=%b valid=%b want 1/1/0", a_if.level, a_if.underflow, a_if.read_valid); end
        a_if.read_en = 1'b1;
        cycle();
        a_if.read_en = 1'b0;
        tests++; if (a_if.read_data !== 8'h5A || a_if.read_valid !== 1'b1 || a_if.empty !== 1'b1) begin fails++; $display("FAIL unf_readback: got data=%h valid=%b empty=%b want 5a/1/1", a_if.read_data, a_if.read_valid, a_if.empty); end
    endtask

    task automatic test_wrap_depth6();
        int  sent = 0;
        int  got = 0;
        logic wr_ok;
        for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
            b_if.write_en = (sent < 20) && ($urandom_range(0, 3) != 0);
            b_if.write_data = 8'(sent + 1);
            b_if.read_en = ($urandom_range(0, 2) != 0);
            wr_ok = b_if.write_en && (qb.size() < 6);
            cycle();
            if (wr_ok) sent++;
            tests++; if (obs_vec_b() !== exp_vec_b()) begin fails++; $display("FAIL wrap_status: got %h want %h", obs_vec_b(), exp_vec_b()); end
            if (exp_rv_b) begin
                tests++; if (b_if.read_data !== 8'(got + 1)) begin fails++; $display("FAIL wrap_order: got %h want %h", b_if.read_data, 8'(got + 1)); end
                got++;
            end
        end
        b_if.write_en = 1'b0; b_if.read_en = 1'b0;
        tests++; if (got != 20) begin fails++; $display("FAIL wrap_count: got %0d words want 20", got); end
    endtask

    task automatic test_fwft();
        f_if.write_en = 1'b1; f_if.write_data = 8'hA5;
        cycle();
        f_if.write_en = 1'b0;
        tests++; if (f_if.read_valid !== 1'b1 || f_if.read_data !== 8'hA5) begin fails++; $display("FAIL fwft_first: got valid=%b data=%h want 1/a5", f_if.read_valid, f_if.read_data); end
        cycle();
        tests++; if (f_if.read_valid !== 1'b1 || f_if.read_data !== 8'hA5 || f_if.level !== 4'd1) begin fails++; $display("FAIL fwft_hold: got valid=%b data=%h level=%0d want 1/a5/1", f_if.read_valid, f_if.read_data, f_if.level); end
        f_if.read_en = 1'b1;
        cycle();
        f_if.read_en = 1'b0;
        tests++; if (f_if.empty !== 1'b1 || f_if.read_valid !== 1'b0) begin fails++; $display("FAIL fwft_ack: got empty=%b valid=%b want 1/0", f_if.empty, f_if.read_valid); end
        f_if.write_en = 1'b1; f_if.write_data = 8'h11;
        cycle();
        f_if.write_data = 8'h22;
        cycle();
        f_if.write_en = 1'b0; f_if.read_en = 1'b1;
        tests++; if (f_if.read_data !== 8'h11) begin fails++; $display("FAIL fwft_head: got %h want 11", f_if.read_data); end
        cycle();
        tests++; if (f_if.read_data !== 8'h22 || f_if.read_valid !== 1'b1) begin fails++; $display("FAIL fwft_next: got data=%h valid=%b want 22/1", f_if.read_data, f_if.read_valid); end
        cycle();
        f_if.read_en = 1'b0;
        tests++; if (obs_vec_f() !== exp_vec_f()) begin fails++; $display("FAIL fwft_drained: got %h want %h", obs_vec_f(), exp_vec_f()); end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 6; i++) begin
            a_if.write_en = 1'b1;
            a_if.read_en = (i == 5);
            a_if.write_data = 8'($urandom);
            cycle();
        end
        tests++; if (a_if.level !== 4'd5 || a_if.read_valid !== 1'b1) begin fails++; $display("FAIL midrst_pre: got level=%0d valid=%b want 5/1", a_if.level, a_if.read_valid); end
        reset = 1'b0;
        model_clear();
        #1;
        tests++; if (a_if.level !== 4'd0 || a_if.empty !== 1'b1 || a_if.read_valid !== 1'b0) begin fails++; $display("FAIL midrst_async: got level=%0d empty=%b valid=%b want 0/1/0", a_if.level, a_if.empty, a_if.read_valid); end
        cycle();
        cycle();
        tests++; if (a_if.level !== 4'd0 || a_if.underflow !== 1'b0) begin fails++; $display("FAIL midrst_ignored: got level=%0d unf=%b want 0/0", a_if.level, a_if.underflow); end
        reset = 1'b1;
        a_if.read_en = 1'b0; a_if.write_en = 1'b1; a_if.write_data = 8'h3C;
        cycle();
        a_if.write_en = 1'b0; a_if.read_en = 1'b1;
        tests++; if (a_if.level !== 4'd1) begin fails++; $display("FAIL midrst_resume: got level=%0d want 1", a_if.level); end
        cycle();
        a_if.read_en = 1'b0;
        tests++; if (a_if.read_data !== 8'h3C || a_if.read_valid !== 1'b1) begin fails++; $display("FAIL midrst_readback: got data=%h valid=%b want 3c/1", a_if.read_data, a_if.read_valid); end
    endtask

    task automatic test_random();
        int wp, rp;
        for (int cyc = 0; cyc < 400; cyc++) begin
            wp = ((cyc / 40) % 2 == 0) ? 75 : 30;
            rp = 100 - wp;
            a_if.write_en = ($urandom_range(0, 99) < wp); a_if.read_en = ($urandom_range(0, 99) < rp);
            b_if.write_en = ($urandom_range(0, 99) < wp); b_if.read_en = ($urandom_range(0, 99) < rp);
            f_if.write_en = ($urandom_range(0, 99) < wp); f_if.read_en = ($urandom_range(0, 99) < rp);
            a_if.write_data = 8'($urandom); b_if.write_data = 8'($urandom); f_if.write_data = 8'($urandom);
            cycle();
            tests++; if (obs_vec_a() !== exp_vec_a()) begin fails++; $display("FAIL rand_a cyc%0d: got %h want %h", cyc, obs_vec_a(), exp_vec_a()); end
            tests++; if (obs_vec_b() !== exp_vec_b()) begin fails++; $display("FAIL rand_b cyc%0d: got %h want %h", cyc, obs_vec_b(), exp_vec_b()); end
            tests++; if (obs_vec_f() !== exp_vec_f()) begin fails++; $display("FAIL rand_f cyc%0d: got %h want %h", cyc, obs_vec_f(), exp_vec_f()); end
            if (qf.size() != 0) begin
                tests++; if (f_if.read_data !== qf[0]) begin fails++; $display("FAIL rand_f_head cyc%0d: got %h want %h", cyc, f_if.read_data, qf[0]); end
            end
        end
        idle_all();
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_level_sweep();
        test_underflow();
        test_wrap_depth6();
        test_fwft();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
